// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: synchronises and deglitches the pins, deserialises 11-bit frames,
// and folds E0/F0 prefixes into a single {extended, scan} event with make/break pulses.
module ps2_scan_decoder #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [8:0] key_code,
    output logic       make,
    output logic       breakk,
    output logic       valid,
    output logic       frame_err
);

    // state  | meaning
    // IDLE   | waiting for a start bit (dat=0 on a falling edge)
    // DATA   | shifting in 8 data bits, LSB first
    // PARITY | sampling the odd-parity bit
    // STOP   | checking the stop bit, accepting or rejecting the byte
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam int FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FILTER_LEN - 1);
    localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   sync_clk, sync_dat;
    logic                   filt_clk;
    logic [FCNT_W-1:0]      filt_cnt;
    logic                   fall;
    logic [WD_W-1:0]        wd_cnt;
    logic                   timeout;
    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift_reg;
    logic                   par_ok;
    logic                   byte_ok, err_d;
    logic                   ext, brk;

    assign sync_clk = clk_sync[SYNC_STAGES-1];
    assign sync_dat = dat_sync[SYNC_STAGES-1];

    // Idle bus is high, so synchronisers and filter come out of reset at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
            if (sync_clk != filt_clk) begin
                if (filt_cnt == FCNT_MAX) begin
                    filt_clk <= sync_clk;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall    = filt_clk && !sync_clk && (filt_cnt == FCNT_MAX);
    assign timeout = (state_q != IDLE) && (wd_cnt == WD_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Watchdog expiry takes priority over a simultaneous edge; the frame restarts on a later fall.
    always_comb begin
        state_d = state_q;
        byte_ok = 1'b0;
        err_d   = 1'b0;
        if (timeout) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else if (fall) begin
            case (state_q)
                IDLE:    if (!sync_dat) state_d = DATA;
                DATA:    if (bit_cnt == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP: begin
                    state_d = IDLE;
                    if (sync_dat && par_ok) byte_ok = 1'b1;
                    else                    err_d   = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt    <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_ok    <= 1'b0;
        end else begin
            if (state_q == IDLE || fall) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (fall && !timeout) begin
                case (state_q)
                    IDLE:    bit_cnt <= '0;
                    DATA: begin
                        shift_reg <= {sync_dat, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                    PARITY:  par_ok <= ^{sync_dat, shift_reg};
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_code  <= '0;
            make      <= 1'b0;
            breakk    <= 1'b0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            ext       <= 1'b0;
            brk       <= 1'b0;
        end else begin
            make      <= 1'b0;
            breakk    <= 1'b0;
            valid     <= 1'b0;
            frame_err <= err_d;
            if (err_d) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_ok) begin
                case (shift_reg)
                    8'hE0:   ext <= 1'b1;
                    8'hF0:   brk <= 1'b1;
                    default: begin
                        key_code <= {ext, shift_reg};
                        valid    <= 1'b1;
                        make     <= ~brk;
                        breakk   <= brk;
                        ext      <= 1'b0;
                        brk      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder: drives PS/2 frames on the pins and checks decoded events.
module tb_ps2_scan_decoder;

    localparam int FL   = 4;
    localparam int TO   = 400;
    localparam int SS   = 2;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk, ps2_dat;
    logic [8:0] key_code;
    logic       make, breakk, valid, frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_valid = 0, n_make = 0, n_brk = 0, n_err = 0;
    int b_valid, b_make, b_brk, b_err;
    int last_valid_cyc = 0, stop_cyc = 0;
    logic [8:0] prev_kc = '0;

    ps2_scan_decoder #(
        .FILTER_LEN(FL),
        .TIMEOUT_CYCLES(TO),
        .SYNC_STAGES(SS)
    ) dut (
        .clk(clk),
        .reset(rst),
        .ps2_clk(ps2_clk),
        .ps2_dat(ps2_dat),
        .key_code(key_code),
        .make(make),
        .breakk(breakk),
        .valid(valid),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse counters count high cycles, so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                n_valid++;
                last_valid_cyc = cyc;
            end
            if (make)      n_make++;
            if (breakk)    n_brk++;
            if (frame_err) n_err++;
            if (make || breakk || valid || frame_err) begin
                check("make_and_break", 32'(make & breakk), 0);
                check("err_and_valid", 32'(frame_err & valid), 0);
            end
            if (key_code !== prev_kc) check("kc_only_with_valid", 32'(valid), 1);
        end
        prev_kc = key_code;
    end

    task automatic snap();
        b_valid = n_valid;
        b_make  = n_make;
        b_brk   = n_brk;
        b_err   = n_err;
    endtask

    task automatic send_frame(input logic [7:0] b, input int nbits, input bit flip_par,
                              input bit bad_stop, input bit glitch);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = fr[i];
            if (glitch && i == 4) begin
                repeat (HALF / 2) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (FL - 1) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (HALF - HALF / 2 - (FL - 1)) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic expect_event(input string tag, input int dv, input int dm, input int db,
                                input int de, input logic [8:0] kc);
        repeat (10) @(negedge clk);
        check({tag, "_valid"}, n_valid - b_valid, dv);
        check({tag, "_make"},  n_make - b_make, dm);
        check({tag, "_break"}, n_brk - b_brk, db);
        check({tag, "_err"},   n_err - b_err, de);
        check({tag, "_code"},  32'(key_code), 32'(kc));
        if (dv == 1) check({tag, "_latency"}, last_valid_cyc - stop_cyc, SS + FL);
    endtask

    initial begin
        rst     = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_outputs", {23'd0, key_code, make, breakk, valid, frame_err}, 0);
        rst = 1'b0;

        snap();
        repeat (10000) @(negedge clk);
        expect_event("idle", 0, 0, 0, 0, 9'h000);

        snap();
        send_frame(8'h6B, 11, 1'b0, 1'b0, 1'b0);
        expect_event("f6b", 1, 1, 0, 0, 9'h06B);

        snap();
        send_frame(8'hE0, 11, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF0, 11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h74, 11, 1'b0, 1'b0, 1'b0);
        expect_event("e0f074", 1, 0, 1, 0, 9'h174);

        snap();
        send_frame(8'h74, 11, 1'b0, 1'b0, 1'b0);
        expect_event("f74", 1, 1, 0, 0, 9'h074);

        snap();
        send_frame(8'h1C, 11, 1'b1, 1'b0, 1'b0);
        expect_event("bad_parity", 0, 0, 0, 1, 9'h074);

        snap();
        send_frame(8'h1C, 11, 1'b0, 1'b0, 1'b0);
        expect_event("f1c", 1, 1, 0, 0, 9'h01C);

        snap();
        send_frame(8'h29, 11, 1'b0, 1'b1, 1'b0);
        expect_event("bad_stop", 0, 0, 0, 1, 9'h01C);

        snap();
        send_frame(8'hF0, 11, 1'b0, 1'b0, 1'b0);
        send_frame(8'hE0, 11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h75, 11, 1'b0, 1'b0, 1'b0);
        expect_event("f0e075", 1, 0, 1, 0, 9'h175);

        snap();
        send_frame(8'hF0, 11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h12, 4, 1'b0, 1'b0, 1'b0);
        repeat (TO + 50) @(negedge clk);
        expect_event("timeout", 0, 0, 0, 1, 9'h175);

        snap();
        send_frame(8'h23, 11, 1'b0, 1'b0, 1'b0);
        expect_event("after_timeout", 1, 1, 0, 0, 9'h023);

        snap();
        send_frame(8'h5A, 11, 1'b0, 1'b0, 1'b1);
        expect_event("glitch", 1, 1, 0, 0, 9'h05A);

        send_frame(8'h33, 5, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset", {23'd0, key_code, make, breakk, valid, frame_err}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);

        snap();
        send_frame(8'h6B, 11, 1'b0, 1'b0, 1'b0);
        expect_event("after_reset", 1, 1, 0, 0, 9'h06B);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
